combo_lock_fsm: RTL and testbench
=================================

# combo_lock_fsm

Parametrised digit-entry combination lock, the successor to the lab 3 fixed six-digit lock. It accepts one digit per valid strobe and compares the finished entry against a programmable stored code. It reports OPEN or ERROR after the last digit and enters a timed LOCKOUT after repeated failures. It sits between the switch/key debouncing front end and the seven-segment display decoder in the lock top level.

## Interface
- DIGITS, 6: digits per combination, range 2..8
- DIGIT_W, 4: bits per digit
- RESET_CODE, 24'h305464: code loaded at reset; digit 0 is the MSB group, so the default sequence is 3,0,5,4,6,4
- MAX_TRIES, 3: consecutive failed entries that trigger lockout, range 1..15
- LOCKOUT_CYCLES, 16: clock cycles spent in LOCKOUT, minimum 1
- clk  in  1  Single clock. All state changes on the rising edge.
- reset_n  in  1  Reset, asynchronous and active-low.
- digit_valid  in  1  One-cycle strobe: `digit` is an entry.
- digit  in  DIGIT_W  Entered digit value.
- clear  in  1  Relocks from OPEN, dismisses ERROR, or aborts an entry in progress.
- code_load  in  1  Latches `code_in` as the new code. Honoured only in OPEN.
- code_in  in  DIGITS*DIGIT_W  New code; same packing as RESET_CODE.
- status  out  3  Lock state: CLOSED, ENTRY, OPEN, ERROR or LOCKOUT (encodings in the defines file).
- entered  out  clog2(DIGITS+1)  Number of digits accepted in the current attempt.
- last_digit  out  DIGIT_W  Most recently accepted digit, echoed for the display.
- fails  out  4  Consecutive failed-attempt count.

## Operation
- States: CLOSED, ENTRY, OPEN, ERROR, LOCKOUT.
- Reset values:
  - status = CLOSED, entered = 0, last_digit = 0, fails = 0.
  - Code register = RESET_CODE; the mismatch flag is cleared.
- CLOSED + digit_valid: go to ENTRY.
  - entered becomes 1 and last_digit is latched.
  - mismatch is set if the digit differs from code digit 0.
- ENTRY + digit_valid at entered = k < DIGITS-1:
  - entered becomes k+1.
  - Mismatch is sticky: it is ORed with the comparison of this digit against code digit k.
  - There is no early rejection; every attempt always consumes DIGITS digits.
- ENTRY + digit_valid on the final digit (k = DIGITS-1): the final comparison is ORed into mismatch, then:
  - No mismatch: go to OPEN; fails becomes 0.
  - Mismatch and fails+1 < MAX_TRIES: go to ERROR; fails increments.
  - Mismatch and fails+1 = MAX_TRIES: go to LOCKOUT; fails increments and the lockout timer is loaded.
- ENTRY + clear: go to CLOSED; entered becomes 0; fails is unchanged.
- OPEN:
  - digit_valid is ignored.
  - code_load latches code_in.
  - clear goes to CLOSED and sets entered to 0.
  - code_load together with clear: the load takes effect and the state goes to CLOSED.
- ERROR:
  - digit_valid is ignored.
  - clear goes to CLOSED and sets entered to 0; fails is kept.
- LOCKOUT:
  - digit_valid, clear and code_load are all ignored.
  - After LOCKOUT_CYCLES cycles: go to CLOSED; fails and entered become 0.
- Priority within one cycle: reset > clear > digit_valid.
- code_load outside OPEN: no effect.
- Digit values outside 0..9 need no special handling; they are compared bitwise like any other value.

## Timing
- All outputs are registered and update on the edge that samples the strobe, so they are visible one cycle after the strobe is presented.
- Outputs after the final-digit edge:
  - status shows OPEN, ERROR or LOCKOUT.
  - entered shows DIGITS.
  - entered holds that value until the state returns to CLOSED.
- LOCKOUT duration: status reads LOCKOUT for exactly LOCKOUT_CYCLES consecutive rising edges, then CLOSED.
- Reset timing: asserting reset_n low at any point, including mid-entry or mid-lockout, forces the reset values immediately without waiting for a clock edge. The first edge after release is a normal CLOSED cycle.
- Back-to-back digit_valid on consecutive cycles are all accepted.

## Structure
- Shared defines file `lock_defs.vh` holds:
  - the five status encodings;
  - the `h0`–`h9` seven-segment constants;
  - the OPEn, CLOSEd and ErrOr display words.
- The display decoder uses the same file.
- Sub-module `lock_timer`: a loadable down-counter, width clog2(LOCKOUT_CYCLES+1), with `load` and `done` ports. It is instantiated once for LOCKOUT.
- Code storage, digit indexing and the state register stay in combo_lock_fsm.

## Test plan
All scenarios use default parameters.
- Correct entry: reset, then digits 3,0,5,4,6,4 on consecutive cycles.
  - One cycle after the last digit: status = OPEN, entered = 6, fails = 0.
- Wrong digit: enter 3,0,5,4,6,5.
  - Response: status = ERROR, fails = 1.
  - A further digit_valid changes nothing.
  - clear gives status = CLOSED, entered = 0, fails = 1.
- Lockout: three wrong entries with clear between them.
  - The third gives LOCKOUT, fails = 3.
  - Digits and clear driven during lockout are ignored.
  - After exactly 16 cycles: status = CLOSED, fails = 0.
- Code change: open with 305464, assert code_load with code_in = 24'h111111 and clear in the same cycle.
  - Response: status = CLOSED.
  - Entering 1,1,1,1,1,1 then gives OPEN; entering 3,0,5,4,6,4 then gives ERROR.
- Abort and reset:
  - clear after 3 digits: status = CLOSED, entered = 0.
  - Separately, reset_n pulsed low mid-lockout between clock edges: all outputs are at reset values before the next edge.
- Parameter sweep: DIGITS = 4, DIGIT_W = 4, RESET_CODE = 16'h1234, MAX_TRIES = 1.
  - Entry 1,2,3,4 gives OPEN.
  - Entry 1,2,3,5 gives LOCKOUT immediately.

Source files
------------

// File: rtl/combo_lock_fsm_pkg.sv
// -----------------------------------------------------------------------------
// combo_lock_fsm_pkg
// Shared definitions for the combination lock and its display decoder:
//   - lock status encodings (the value driven on combo_lock_fsm.status)
//   - seven-segment glyphs for hex digits 0..9 (active-high, bit order gfedcba)
//   - the OPEn / CLOSEd / ErrOr display words, six glyphs each, left-aligned,
//     leftmost glyph in the most significant 7 bits
//   - a digit-to-glyph helper for the display side
// -----------------------------------------------------------------------------
package combo_lock_fsm_pkg;

    // Lock status; the encoding is visible on the status port.
    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_ERROR   = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_e;

    // Seven-segment digit glyphs, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG_H0    = 7'h3F;
    localparam logic [6:0] SEG_H1    = 7'h06;
    localparam logic [6:0] SEG_H2    = 7'h5B;
    localparam logic [6:0] SEG_H3    = 7'h4F;
    localparam logic [6:0] SEG_H4    = 7'h66;
    localparam logic [6:0] SEG_H5    = 7'h6D;
    localparam logic [6:0] SEG_H6    = 7'h7D;
    localparam logic [6:0] SEG_H7    = 7'h07;
    localparam logic [6:0] SEG_H8    = 7'h7F;
    localparam logic [6:0] SEG_H9    = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Letter glyphs used by the status words.
    localparam logic [6:0] SEG_UC_O  = 7'h3F;
    localparam logic [6:0] SEG_UC_P  = 7'h73;
    localparam logic [6:0] SEG_UC_E  = 7'h79;
    localparam logic [6:0] SEG_LC_N  = 7'h54;
    localparam logic [6:0] SEG_UC_C  = 7'h39;
    localparam logic [6:0] SEG_UC_L  = 7'h38;
    localparam logic [6:0] SEG_UC_S  = 7'h6D;
    localparam logic [6:0] SEG_LC_D  = 7'h5E;
    localparam logic [6:0] SEG_LC_R  = 7'h50;
    localparam logic [6:0] SEG_LC_O  = 7'h5C;

    // Six-glyph display words.
    localparam logic [41:0] WORD_OPEN  = {SEG_UC_O, SEG_UC_P, SEG_UC_E, SEG_LC_N,
                                          SEG_BLANK, SEG_BLANK};
    localparam logic [41:0] WORD_CLOSED = {SEG_UC_C, SEG_UC_L, SEG_UC_O, SEG_UC_S,
                                           SEG_UC_E, SEG_LC_D};
    localparam logic [41:0] WORD_ERROR = {SEG_UC_E, SEG_LC_R, SEG_LC_R, SEG_LC_O,
                                          SEG_LC_R, SEG_BLANK};

    // Glyph for a decimal digit; anything outside 0..9 shows blank.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_H0;
            4'd1:    seg = SEG_H1;
            4'd2:    seg = SEG_H2;
            4'd3:    seg = SEG_H3;
            4'd4:    seg = SEG_H4;
            4'd5:    seg = SEG_H5;
            4'd6:    seg = SEG_H6;
            4'd7:    seg = SEG_H7;
            4'd8:    seg = SEG_H8;
            4'd9:    seg = SEG_H9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/combo_lock_fsm_timer.sv
// -----------------------------------------------------------------------------
// lock_timer
// Loadable down-counter used to time the LOCKOUT state. The count parks at
// zero; done is high whenever the registered count is zero.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (count -> 0, done -> 1)
//   load     in   load load_val on this edge (takes priority over counting)
//   load_val in   W-bit value to load
//   done     out  registered: count is zero
// -----------------------------------------------------------------------------
module lock_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q, count_d;
    logic         done_q, done_d;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        if (load) begin
            count_d = load_val;
        end else if (count_q != {W{1'b0}}) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
        done_d = (count_d == {W{1'b0}});
    end

    // Count and done registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {W{1'b0}};
            done_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/combo_lock_fsm.sv
// -----------------------------------------------------------------------------
// combo_lock_fsm
// Digit-entry combination lock. One digit is accepted per digit_valid strobe;
// after DIGITS digits the entry is compared against the stored code and the
// lock reports OPEN, ERROR, or (after MAX_TRIES consecutive failures) a timed
// LOCKOUT of LOCKOUT_CYCLES clocks.
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   digit_valid in   one-cycle strobe qualifying digit
//   digit       in   entered digit value (DIGIT_W bits)
//   clear       in   relock from OPEN, dismiss ERROR, or abort an entry
//   code_load   in   latch code_in as the new code (only honoured in OPEN)
//   code_in     in   new code, digit 0 in the most significant group
//   status      out  lock state (lock_state_e encoding)
//   entered     out  digits accepted in the current attempt
//   last_digit  out  most recently accepted digit
//   fails       out  consecutive failed-attempt count
// All outputs are registered.
// -----------------------------------------------------------------------------
module combo_lock_fsm
    import combo_lock_fsm_pkg::*;
#(
    parameter int                          DIGITS         = 6,
    parameter int                          DIGIT_W        = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]   RESET_CODE     = 24'h305464,
    parameter int                          MAX_TRIES      = 3,
    parameter int                          LOCKOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             digit_valid,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             clear,
    input  logic                             code_load,
    input  logic [DIGITS*DIGIT_W-1:0]        code_in,
    output logic [2:0]                       status,
    output logic [$clog2(DIGITS+1)-1:0]      entered,
    output logic [DIGIT_W-1:0]               last_digit,
    output logic [3:0]                       fails
);

    localparam int EW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [EW-1:0] ENT_LAST    = EW'(DIGITS - 1);
    localparam logic [EW-1:0] ENT_FULL    = EW'(DIGITS);
    localparam logic [3:0]    TRIES_LIMIT = 4'(MAX_TRIES);
    // The timer is checked on the edge after it reaches zero, so loading
    // LOCKOUT_CYCLES-1 yields exactly LOCKOUT_CYCLES cycles in LOCKOUT.
    localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);

    lock_state_e                 state_q, state_d;
    logic [DIGITS*DIGIT_W-1:0]   code_q, code_d;
    logic [EW-1:0]               entered_q, entered_d;
    logic [DIGIT_W-1:0]          last_q, last_d;
    logic [3:0]                  fails_q, fails_d;
    logic                        mismatch_q, mismatch_d;

    logic [DIGIT_W-1:0]          expect_digit_s;
    logic                        digit_miss_s;
    logic                        attempt_miss_s;
    logic [3:0]                  fails_inc_s;
    logic                        timer_load_s;
    logic                        timer_done_s;

    lock_timer #(
        .W (TW)
    ) u_lock_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load_s),
        .load_val (LOCK_LOAD),
        .done     (timer_done_s)
    );

    // Select the stored code digit matching the current entry position.
    // entered is 0 in CLOSED, so this also covers the first digit.
    always_comb begin
        expect_digit_s = {DIGIT_W{1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            if (entered_q == EW'(k)) begin
                expect_digit_s = code_q[(DIGITS-1-k)*DIGIT_W +: DIGIT_W];
            end else begin
                expect_digit_s = expect_digit_s;
            end
        end
    end

    assign digit_miss_s   = (digit != expect_digit_s);
    assign attempt_miss_s = mismatch_q | digit_miss_s;
    assign fails_inc_s    = fails_q + 4'd1;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        entered_d    = entered_q;
        last_d       = last_q;
        fails_d      = fails_q;
        mismatch_d   = mismatch_q;
        timer_load_s = 1'b0;

        case (state_q)
            ST_CLOSED: begin
                if (clear) begin
                    entered_d = {EW{1'b0}};
                end else if (digit_valid) begin
                    state_d    = ST_ENTRY;
                    entered_d  = EW'(1);
                    last_d     = digit;
                    mismatch_d = digit_miss_s;
                end else begin
                    state_d = ST_CLOSED;
                end
            end

            ST_ENTRY: begin
                if (clear) begin
                    state_d    = ST_CLOSED;
                    entered_d  = {EW{1'b0}};
                    mismatch_d = 1'b0;
                end else if (digit_valid) begin
                    last_d = digit;
                    if (entered_q == ENT_LAST) begin
                        // Final digit: resolve the whole attempt.
                        entered_d  = ENT_FULL;
                        mismatch_d = attempt_miss_s;
                        if (!attempt_miss_s) begin
                            state_d = ST_OPEN;
                            fails_d = 4'd0;
                        end else if (fails_inc_s >= TRIES_LIMIT) begin
                            state_d      = ST_LOCKOUT;
                            fails_d      = fails_inc_s;
                            timer_load_s = 1'b1;
                        end else begin
                            state_d = ST_ERROR;
                            fails_d = fails_inc_s;
                        end
                    end else begin
                        // No early rejection: a miss only marks the attempt.
                        entered_d  = entered_q + EW'(1);
                        mismatch_d = attempt_miss_s;
                    end
                end else begin
                    state_d = ST_ENTRY;
                end
            end

            ST_OPEN: begin
                // A load issued together with clear still takes effect.
                if (code_load) begin
                    code_d = code_in;
                end else begin
                    code_d = code_q;
                end
                if (clear) begin
                    state_d   = ST_CLOSED;
                    entered_d = {EW{1'b0}};
                end else begin
                    state_d = ST_OPEN;
                end
            end

            ST_ERROR: begin
                if (clear) begin
                    state_d   = ST_CLOSED;
                    entered_d = {EW{1'b0}};
                end else begin
                    state_d = ST_ERROR;
                end
            end

            ST_LOCKOUT: begin
                // All inputs are ignored until the timer runs out.
                if (timer_done_s) begin
                    state_d    = ST_CLOSED;
                    entered_d  = {EW{1'b0}};
                    fails_d    = 4'd0;
                    mismatch_d = 1'b0;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end

            default: begin
                state_d    = ST_CLOSED;
                entered_d  = {EW{1'b0}};
                mismatch_d = 1'b0;
            end
        endcase
    end

    // State, code and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_CLOSED;
            code_q     <= RESET_CODE;
            entered_q  <= {EW{1'b0}};
            last_q     <= {DIGIT_W{1'b0}};
            fails_q    <= 4'd0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            entered_q  <= entered_d;
            last_q     <= last_d;
            fails_q    <= fails_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign status     = state_q;
    assign entered    = entered_q;
    assign last_digit = last_q;
    assign fails      = fails_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// -----------------------------------------------------------------------------
// tb_combo_lock_fsm
// Self-checking bench for combo_lock_fsm: a default-parameter instance driven
// from a vector table plus hand-written lockout/reset sequences, and a
// 4-digit MAX_TRIES=1 instance. Expected outputs are queued when a step is
// driven and compared one clock later when the registered outputs appear.
// -----------------------------------------------------------------------------
module tb_combo_lock_fsm;
    import combo_lock_fsm_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, reset4_n;
    logic        digit_valid, clear, code_load;
    logic [3:0]  digit;
    logic [23:0] code_in;
    logic [2:0]  status, status4;
    logic [2:0]  entered, entered4;
    logic [3:0]  last_digit, last4, fails, fails4;

    combo_lock_fsm dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digit_valid (digit_valid),
        .digit       (digit),
        .clear       (clear),
        .code_load   (code_load),
        .code_in     (code_in),
        .status      (status),
        .entered     (entered),
        .last_digit  (last_digit),
        .fails       (fails)
    );

    combo_lock_fsm #(
        .DIGITS     (4),
        .DIGIT_W    (4),
        .RESET_CODE (16'h1234),
        .MAX_TRIES  (1)
    ) dut4 (
        .clk         (clk),
        .reset_n     (reset4_n),
        .digit_valid (digit_valid),
        .digit       (digit),
        .clear       (clear),
        .code_load   (code_load),
        .code_in     (code_in[15:0]),
        .status      (status4),
        .entered     (entered4),
        .last_digit  (last4),
        .fails       (fails4)
    );

    typedef struct {
        string       name;
        bit          sel4;
        logic        dv;
        logic [3:0]  d;
        logic        clr;
        logic        ld;
        logic [23:0] cin;
        logic [2:0]  st;
        logic [2:0]  ent;
        logic [3:0]  last;
        logic [3:0]  fl;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input string n, input bit s4, input logic dv, input logic [3:0] d,
                                input logic clr, input logic ld, input logic [23:0] cin,
                                input logic [2:0] st, input logic [2:0] ent,
                                input logic [3:0] last, input logic [3:0] fl);
        vec_t v;
        v.name = n; v.sel4 = s4; v.dv = dv; v.d = d; v.clr = clr; v.ld = ld; v.cin = cin;
        v.st = st; v.ent = ent; v.last = last; v.fl = fl;
        return v;
    endfunction

    // Six-digit attempt on the default instance; digits 0..4 land in ENTRY.
    task automatic add_seq(input string n, input logic [23:0] code, input logic [2:0] fin_st,
                           input logic [3:0] f_before, input logic [3:0] f_after);
        logic [3:0] dg;
        for (int k = 0; k < 6; k++) begin
            dg = code[(5-k)*4 +: 4];
            if (k < 5) begin
                tbl.push_back(mk($sformatf("%s_d%0d", n, k), 1'b0, 1'b1, dg, 1'b0, 1'b0, 24'h0,
                                 ST_ENTRY, 3'(k + 1), dg, f_before));
            end else begin
                tbl.push_back(mk($sformatf("%s_d%0d", n, k), 1'b0, 1'b1, dg, 1'b0, 1'b0, 24'h0,
                                 fin_st, 3'd6, dg, f_after));
            end
        end
    endtask

    task automatic compare_out();
        vec_t       e;
        logic [2:0] st, ent;
        logic [3:0] ld, fl;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected one entry");
            return;
        end
        e   = exp_q.pop_front();
        st  = e.sel4 ? status4  : status;
        ent = e.sel4 ? entered4 : entered;
        ld  = e.sel4 ? last4    : last_digit;
        fl  = e.sel4 ? fails4   : fails;
        check({e.name, ".status"},  32'(st),  32'(e.st));
        check({e.name, ".entered"}, 32'(ent), 32'(e.ent));
        check({e.name, ".last"},    32'(ld),  32'(e.last));
        check({e.name, ".fails"},   32'(fl),  32'(e.fl));
    endtask

    task automatic step(input vec_t v);
        digit_valid = v.dv;
        digit       = v.d;
        clear       = v.clr;
        code_load   = v.ld;
        code_in     = v.cin;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        clear       = 1'b0;
        code_load   = 1'b0;
        compare_out();
    endtask

    task automatic check_reset(input string n);
        check({n, ".status"},  32'(status),     32'(ST_CLOSED));
        check({n, ".entered"}, 32'(entered),    32'd0);
        check({n, ".last"},    32'(last_digit), 32'd0);
        check({n, ".fails"},   32'(fails),      32'd0);
    endtask

    int idx_a;

    initial begin
        reset_n     = 1'b0;
        reset4_n    = 1'b0;
        digit_valid = 1'b0;
        clear       = 1'b0;
        code_load   = 1'b0;
        digit       = 4'd0;
        code_in     = 24'h0;

        // Part A: correct entry, wrong entry, abort, then three failures.
        add_seq("open", 24'h305464, ST_OPEN, 4'd0, 4'd0);
        tbl.push_back(mk("open_dv_ign", 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 24'h0, ST_OPEN, 3'd6, 4'd4, 4'd0));
        tbl.push_back(mk("open_clr", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 24'h0, ST_CLOSED, 3'd0, 4'd4, 4'd0));
        add_seq("wrong1", 24'h305465, ST_ERROR, 4'd0, 4'd1);
        tbl.push_back(mk("err_dv_ign", 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 24'h0, ST_ERROR, 3'd6, 4'd5, 4'd1));
        tbl.push_back(mk("err_ld_ign", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 24'h111111, ST_ERROR, 3'd6, 4'd5, 4'd1));
        tbl.push_back(mk("err_clr", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 24'h0, ST_CLOSED, 3'd0, 4'd5, 4'd1));
        tbl.push_back(mk("abort_d0", 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 24'h0, ST_ENTRY, 3'd1, 4'd3, 4'd1));
        tbl.push_back(mk("abort_d1", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 24'h0, ST_ENTRY, 3'd2, 4'd0, 4'd1));
        tbl.push_back(mk("abort_d2", 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 24'h0, ST_ENTRY, 3'd3, 4'd5, 4'd1));
        tbl.push_back(mk("abort_clr", 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 24'h0, ST_CLOSED, 3'd0, 4'd5, 4'd1));
        add_seq("wrong2", 24'h999999, ST_ERROR, 4'd1, 4'd2);
        tbl.push_back(mk("wrong2_clr", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 24'h0, ST_CLOSED, 3'd0, 4'd9, 4'd2));
        add_seq("wrong3", 24'h305460, ST_LOCKOUT, 4'd2, 4'd3);
        idx_a = tbl.size();

        // Part B: code change with load+clear, then failures back to lockout.
        add_seq("open2", 24'h305464, ST_OPEN, 4'd0, 4'd0);
        tbl.push_back(mk("load_clr", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 24'h111111, ST_CLOSED, 3'd0, 4'd4, 4'd0));
        add_seq("newcode", 24'h111111, ST_OPEN, 4'd0, 4'd0);
        tbl.push_back(mk("open_ld", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 24'h111111, ST_OPEN, 3'd6, 4'd1, 4'd0));
        tbl.push_back(mk("open_clr2", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 24'h0, ST_CLOSED, 3'd0, 4'd1, 4'd0));
        add_seq("oldcode", 24'h305464, ST_ERROR, 4'd0, 4'd1);
        tbl.push_back(mk("oldcode_clr", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 24'h0, ST_CLOSED, 3'd0, 4'd4, 4'd1));
        add_seq("oldcode2", 24'h305464, ST_ERROR, 4'd1, 4'd2);
        tbl.push_back(mk("oldcode2_clr", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 24'h0, ST_CLOSED, 3'd0, 4'd4, 4'd2));
        add_seq("oldcode3", 24'h305464, ST_LOCKOUT, 4'd2, 4'd3);

        // Reset values appear without any clock edge having occurred.
        #3;
        check_reset("reset0");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < idx_a; i++) begin
            step(tbl[i]);
        end

        // 15 more LOCKOUT cycles (16 total) with inputs that must be ignored.
        for (int i = 1; i < 16; i++) begin
            step(mk($sformatf("lock_hold%0d", i), 1'b0, i[0], 4'd4, ~i[0], 1'b1, 24'h111111,
                    ST_LOCKOUT, 3'd6, 4'd0, 4'd3));
        end
        step(mk("lock_exit", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 24'h0, ST_CLOSED, 3'd0, 4'd0, 4'd0));

        for (int i = idx_a; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Asynchronous reset mid-lockout, between clock edges.
        for (int i = 0; i < 3; i++) begin
            step(mk($sformatf("lock2_hold%0d", i), 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 24'h0,
                    ST_LOCKOUT, 3'd6, 4'd4, 4'd3));
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(mk("post_reset_d0", 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 24'h0, ST_ENTRY, 3'd1, 4'd3, 4'd0));
        step(mk("post_reset_clr", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 24'h0, ST_CLOSED, 3'd0, 4'd3, 4'd0));

        // Four-digit instance, single try before lockout.
        @(negedge clk);
        reset_n  = 1'b0;
        reset4_n = 1'b1;
        step(mk("p4_d0", 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 24'h0, ST_ENTRY, 3'd1, 4'd1, 4'd0));
        step(mk("p4_d1", 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 24'h0, ST_ENTRY, 3'd2, 4'd2, 4'd0));
        step(mk("p4_d2", 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 24'h0, ST_ENTRY, 3'd3, 4'd3, 4'd0));
        step(mk("p4_d3", 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 24'h0, ST_OPEN, 3'd4, 4'd4, 4'd0));
        step(mk("p4_clr", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 24'h0, ST_CLOSED, 3'd0, 4'd4, 4'd0));
        step(mk("p4_w0", 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 24'h0, ST_ENTRY, 3'd1, 4'd1, 4'd0));
        step(mk("p4_w1", 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 24'h0, ST_ENTRY, 3'd2, 4'd2, 4'd0));
        step(mk("p4_w2", 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 24'h0, ST_ENTRY, 3'd3, 4'd3, 4'd0));
        step(mk("p4_w3", 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 24'h0, ST_LOCKOUT, 3'd4, 4'd5, 4'd1));
        step(mk("p4_lock_clr", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 24'h0, ST_LOCKOUT, 3'd4, 4'd5, 4'd1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
